mult_div_seq: RTL and testbench

Iterative signed multiply/divide sequencer that owns the Hi/Lo register pair of the multicycle MIPS datapath. The control unit starts it with a one-cycle `start` pulse carrying the A/B register values, then waits for `done`. Hi/Lo outputs feed the write-data mux for `mfhi`/`mflo`. Multiply uses radix-2 Booth; divide uses restoring division on magnitudes with a sign fix-up.

---
 rtl/mult_div_seq_pkg.sv | 15 +
 rtl/mult_div_seq_if.sv | 27 ++
 rtl/mult_div_seq.sv | 188 ++++++++++++++++++
 tb/tb_mult_div_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_seq_pkg.sv
// Shared CPU constants for the multiply/divide sequencer: FSM state
// encoding and the mult/div op encoding also used by the control unit.
package mult_div_seq_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_seq_if.sv
// Control-unit <-> mult/div sequencer bus. The control unit is the master:
// it issues start/op/operands and observes status plus the Hi/Lo pair.
interface mult_div_seq_if #(
  parameter int DATA_W = 32
) ();

  logic              start;
  logic              op;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out
  );

endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide sequencer owning the Hi/Lo registers.
// Multiply: radix-2 Booth, one step per cycle. Divide: restoring division
// on magnitudes, one step per cycle, followed by a sign fix-up cycle.
module mult_div_seq
  import mult_div_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ONE_W     = {{(DATA_W-1){1'b0}}, 1'b1};

  // Two's-complement negate (mod 2^DATA_W) when en is set.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic en);
    neg_if = en ? (~v + ONE_W) : v;
  endfunction

  // FSM and status registers
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;

  // Datapath registers. acc_r is the Booth accumulator (one guard bit so the
  // most negative multiplicand cannot overflow) and doubles as the divide
  // remainder; sreg_r is the multiplier shift register / quotient; opnd_r is
  // the multiplicand / divisor magnitude.
  logic              op_r;
  logic              sign_a_r;
  logic              sign_b_r;
  logic [DATA_W:0]   acc_r;
  logic [DATA_W-1:0] sreg_r;
  logic [DATA_W-1:0] opnd_r;
  logic              q_m1_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  // Combinational helpers
  logic              accept_s;
  logic              dz_s;
  logic [DATA_W:0]   m_ext_s;
  logic [DATA_W:0]   booth_sum_s;
  logic [DATA_W:0]   div_shift_s;
  logic [DATA_W+1:0] div_diff_s;

  assign accept_s = (state_r == ST_IDLE) && bus.start &&
                    ((bus.op == OP_MULT) || (bus.b_in != {DATA_W{1'b0}}));
  assign dz_s     = (state_r == ST_IDLE) && bus.start &&
                    (bus.op == OP_DIV) && (bus.b_in == {DATA_W{1'b0}});

  // Next-state decode for the sequencer FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else if (dz_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIX:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One arithmetic step: Booth add/sub of the multiplicand, or restoring
  // trial subtraction of the divisor magnitude from the shifted remainder.
  always_comb begin
    m_ext_s = {opnd_r[DATA_W-1], opnd_r};
    case ({sreg_r[0], q_m1_r})
      2'b01:   booth_sum_s = acc_r + m_ext_s;
      2'b10:   booth_sum_s = acc_r - m_ext_s;
      default: booth_sum_s = acc_r;
    endcase
    div_shift_s = {acc_r[DATA_W-1:0], sreg_r[DATA_W-1]};
    div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_r};
  end

  // FSM state, step counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_FIX);
      done_r     <= (state_nxt_s == ST_DONE);
      div_zero_r <= dz_s;
      if (accept_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Datapath: operand latch, iteration steps, and Hi/Lo write-back at FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= OP_MULT;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      acc_r    <= {(DATA_W+1){1'b0}};
      sreg_r   <= {DATA_W{1'b0}};
      opnd_r   <= {DATA_W{1'b0}};
      q_m1_r   <= 1'b0;
      hi_r     <= {DATA_W{1'b0}};
      lo_r     <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r     <= bus.op;
            sign_a_r <= bus.a_in[DATA_W-1];
            sign_b_r <= bus.b_in[DATA_W-1];
            acc_r    <= {(DATA_W+1){1'b0}};
            q_m1_r   <= 1'b0;
            if (bus.op == OP_MULT) begin
              opnd_r <= bus.a_in;
              sreg_r <= bus.b_in;
            end else begin
              opnd_r <= neg_if(bus.b_in, bus.b_in[DATA_W-1]);
              sreg_r <= neg_if(bus.a_in, bus.a_in[DATA_W-1]);
            end
          end
        end
        ST_RUN: begin
          if (op_r == OP_MULT) begin
            // Arithmetic right shift of {acc, multiplier, q-1}.
            acc_r  <= {booth_sum_s[DATA_W], booth_sum_s[DATA_W:1]};
            sreg_r <= {booth_sum_s[0], sreg_r[DATA_W-1:1]};
            q_m1_r <= sreg_r[0];
          end else if (div_diff_s[DATA_W+1]) begin
            acc_r  <= div_shift_s;
            sreg_r <= {sreg_r[DATA_W-2:0], 1'b0};
          end else begin
            acc_r  <= div_diff_s[DATA_W:0];
            sreg_r <= {sreg_r[DATA_W-2:0], 1'b1};
          end
        end
        ST_FIX: begin
          if (op_r == OP_MULT) begin
            hi_r <= acc_r[DATA_W-1:0];
            lo_r <= sreg_r;
          end else begin
            lo_r <= neg_if(sreg_r, sign_a_r ^ sign_b_r);
            hi_r <= neg_if(acc_r[DATA_W-1:0], sign_a_r);
          end
        end
        default: begin
          hi_r <= hi_r;
          lo_r <= lo_r;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.hi_out   = hi_r;
  assign bus.lo_out   = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: a reference model computes the
// expected Hi/Lo/div_zero at issue time into a scoreboard queue, which is
// popped and compared when done is observed.
module tb_mult_div_seq;
  import mult_div_seq_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } res_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  res_t sb_q[$];
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  mult_div_seq_if #(.DATA_W(W)) mdi ();

  mult_div_seq #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compute the expected result, push it, and pulse start for one edge.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    longint p;
    longint q;
    longint r;
    if (o == OP_MULT) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
    end else if (b == 32'd0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      e.hi = r[31:0];
      e.lo = q[31:0];
      e.dz = 1'b0;
    end
    model_hi = e.hi;
    model_lo = e.lo;
    sb_q.push_back(e);
    @(negedge clk);
    mdi.start = 1'b1;
    mdi.op    = o;
    mdi.a_in  = a;
    mdi.b_in  = b;
    @(negedge clk);
    mdi.start = 1'b0;
  endtask

  // Wait (bounded) for done; n = cycle index after E0 where done is seen.
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output res_t exp_r, output res_t got_r, output int n,
                        output int busy_cnt, output bit timeout);
    int i;
    bit got;
    issue(o, a, b);
    i = 1; got = 1'b0; n = 0; busy_cnt = 0;
    while (!got && i <= 200) begin
      if (mdi.done === 1'b1) begin
        got = 1'b1;
        n = i;
      end else begin
        if (mdi.busy === 1'b1) busy_cnt++;
        @(negedge clk);
        i++;
      end
    end
    timeout = !got;
    exp_r = sb_q.pop_front();
    got_r = {mdi.hi_out, mdi.lo_out, mdi.div_zero};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mdi.start = 1'b0; mdi.op = OP_MULT; mdi.a_in = 32'd0; mdi.b_in = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    tests_run++;
    if ({mdi.busy, mdi.done, mdi.div_zero} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b exp=000", {mdi.busy, mdi.done, mdi.div_zero});
    end
    tests_run++;
    if ({mdi.hi_out, mdi.lo_out} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_hilo got hi=%h lo=%h exp 0/0", mdi.hi_out, mdi.lo_out);
    end
  endtask

  task automatic test_mult();
    logic [W-1:0] av [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF};
    logic [W-1:0] bv [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 32'h8000_0000};
    res_t e, g; int n, bc; bit to;
    for (int k = 0; k < 5; k++) begin
      run_op(OP_MULT, av[k], bv[k], e, g, n, bc, to);
      tests_run++;
      if (to || g !== e) begin
        tests_failed++;
        $display("FAIL mult[%0d] got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b timeout=%b",
                 k, g.hi, g.lo, g.dz, e.hi, e.lo, e.dz, to);
      end
      if (k == 0) begin
        tests_run++;
        if (n !== 34 || bc !== 33) begin
          tests_failed++;
          $display("FAIL mult_timing got done_cycle=%0d busy_cycles=%0d exp 34/33", n, bc);
        end
        @(negedge clk);
        tests_run++;
        if (mdi.done !== 1'b0) begin
          tests_failed++;
          $display("FAIL done_one_cycle got done=%b exp 0", mdi.done);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] av [6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'd100, 32'd3};
    logic [W-1:0] bv [6] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7, 32'd10};
    res_t e, g; int n, bc; bit to;
    for (int k = 0; k < 6; k++) begin
      run_op(OP_DIV, av[k], bv[k], e, g, n, bc, to);
      tests_run++;
      if (to || g !== e || n !== 34) begin
        tests_failed++;
        $display("FAIL div[%0d] got hi=%h lo=%h dz=%b cyc=%0d exp hi=%h lo=%h dz=%b cyc=34",
                 k, g.hi, g.lo, g.dz, n, e.hi, e.lo, e.dz);
      end
    end
  endtask

  task automatic test_div_zero();
    res_t e, g; int n, bc; bit to;
    run_op(OP_MULT, 32'h0001_0003, 32'hFFFF_0005, e, g, n, bc, to);
    run_op(OP_DIV, 32'd5, 32'd0, e, g, n, bc, to);
    tests_run++;
    if (to || g !== e) begin
      tests_failed++;
      $display("FAIL div_zero got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
               g.hi, g.lo, g.dz, e.hi, e.lo, e.dz);
    end
    tests_run++;
    if (n !== 1 || bc !== 0 || mdi.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_zero_timing got done_cycle=%0d busy_cycles=%0d exp 1/0", n, bc);
    end
  endtask

  task automatic test_ignore_start();
    res_t e, g; int i, bc; bit got;
    issue(OP_MULT, 32'hFFFF_F001, 32'd12345);
    repeat (8) @(negedge clk);
    tests_run++;
    if (mdi.hi_out !== 32'h0001_0003 * 32'd0 + dut_prev_hi() || mdi.lo_out !== dut_prev_lo()) begin
      tests_failed++;
      $display("FAIL hilo_stable_run got hi=%h lo=%h exp hi=%h lo=%h",
               mdi.hi_out, mdi.lo_out, dut_prev_hi(), dut_prev_lo());
    end
    mdi.start = 1'b1; mdi.op = OP_DIV; mdi.a_in = 32'd99; mdi.b_in = 32'd4;
    @(negedge clk);
    mdi.start = 1'b0; mdi.a_in = 32'hDEAD_BEEF;
    @(negedge clk);
    mdi.a_in = 32'h0;
    i = 0; got = 1'b0;
    while (!got && i < 200) begin
      if (mdi.done === 1'b1) got = 1'b1;
      else begin @(negedge clk); i++; end
    end
    e = sb_q.pop_front();
    g = {mdi.hi_out, mdi.lo_out, mdi.div_zero};
    tests_run++;
    if (!got || g !== e) begin
      tests_failed++;
      $display("FAIL ignore_start got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
               g.hi, g.lo, g.dz, e.hi, e.lo, e.dz);
    end
    bc = 0;
  endtask

  // Hi/Lo held by the model before the in-flight op (the previous result).
  res_t prev_r;
  function automatic logic [W-1:0] dut_prev_hi(); return prev_r.hi; endfunction
  function automatic logic [W-1:0] dut_prev_lo(); return prev_r.lo; endfunction

  task automatic test_back_to_back();
    res_t e, g; int n, bc; bit to;
    run_op(OP_DIV, 32'hFFFF_FC18, 32'd33, e, g, n, bc, to);
    tests_run++;
    if (to || g !== e) begin
      tests_failed++;
      $display("FAIL b2b_first got hi=%h lo=%h exp hi=%h lo=%h", g.hi, g.lo, e.hi, e.lo);
    end
    run_op(OP_MULT, 32'hFFFF_FFF6, 32'hFFFF_FFF6, e, g, n, bc, to);
    tests_run++;
    if (to || g !== e || n !== 34) begin
      tests_failed++;
      $display("FAIL b2b_second got hi=%h lo=%h cyc=%0d exp hi=%h lo=%h cyc=34",
               g.hi, g.lo, n, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid_div();
    res_t e, g; int n, bc; bit to;
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb_q.pop_front());
    model_hi = 32'd0; model_lo = 32'd0;
    tests_run++;
    if ({mdi.busy, mdi.done, mdi.div_zero} !== 3'b000 || {mdi.hi_out, mdi.lo_out} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_div got flags=%b hi=%h lo=%h exp 000/0/0",
               {mdi.busy, mdi.done, mdi.div_zero}, mdi.hi_out, mdi.lo_out);
    end
    run_op(OP_MULT, 32'd2, 32'd3, e, g, n, bc, to);
    tests_run++;
    if (to || g !== {32'd0, 32'd6, 1'b0}) begin
      tests_failed++;
      $display("FAIL post_reset_mult got hi=%h lo=%h dz=%b exp hi=0 lo=6 dz=0", g.hi, g.lo, g.dz);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    prev_r = {model_hi, model_lo, 1'b0};
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
